// File: rtl/screen_arbiter.sv
// ----------------------------------------------------------------------------
// screen_arbiter : round-robin owner arbitration of one screen_writer among N
//                  drawing engines, with command mux and done routing.
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module screen_arbiter #(
  parameter int WIDTH        = 16,
  parameter int COLOUR_WIDTH = 3,
  parameter int N            = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N-1:0]              req,
  output logic [N-1:0]              grant,
  input  logic [N-1:0]              rq_screen_start,
  input  logic [N*COLOUR_WIDTH-1:0] rq_new_screen_colour,
  input  logic [N*WIDTH-1:0]        rq_screen_x_min,
  input  logic [N*WIDTH-1:0]        rq_screen_y_min,
  input  logic [N*WIDTH-1:0]        rq_screen_x_range,
  input  logic [N*WIDTH-1:0]        rq_screen_y_range,
  output logic [N-1:0]              rq_screen_done,
  output logic [WIDTH-1:0]          rq_screen_x,
  output logic [WIDTH-1:0]          rq_screen_y,
  output logic [COLOUR_WIDTH-1:0]   rq_old_screen_colour,
  output logic                      screen_start,
  output logic [COLOUR_WIDTH-1:0]   new_screen_colour,
  output logic [WIDTH-1:0]          screen_x_min,
  output logic [WIDTH-1:0]          screen_y_min,
  output logic [WIDTH-1:0]          screen_x_range,
  output logic [WIDTH-1:0]          screen_y_range,
  input  logic [WIDTH-1:0]          screen_x,
  input  logic [WIDTH-1:0]          screen_y,
  input  logic [COLOUR_WIDTH-1:0]   old_screen_colour,
  input  logic                      screen_done
);

  localparam int OW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_grant;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   r_ptr;

  logic            w_found;
  logic [OW-1:0]   w_pick;
  logic [OW-1:0]   w_owner_next;
  logic            w_owner_start;
  logic            w_owner_req;
  logic            w_active;
  logic [COLOUR_WIDTH-1:0] w_colour;
  logic [WIDTH-1:0] w_x_min;
  logic [WIDTH-1:0] w_y_min;
  logic [WIDTH-1:0] w_x_range;
  logic [WIDTH-1:0] w_y_range;

  // Round-robin search: descending scan so the smallest offset from ptr wins.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx[OW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = idx[OW-1:0];
      end
    end
  end

  always_comb begin
    w_owner_start = 1'b0;
    w_owner_req   = 1'b0;
    w_colour      = '0;
    w_x_min       = '0;
    w_y_min       = '0;
    w_x_range     = '0;
    w_y_range     = '0;
    for (int i = 0; i < N; i++) begin
      if (r_owner == OW'(i)) begin
        w_owner_start = rq_screen_start[i];
        w_owner_req   = req[i];
        w_colour      = rq_new_screen_colour[i*COLOUR_WIDTH +: COLOUR_WIDTH];
        w_x_min       = rq_screen_x_min[i*WIDTH +: WIDTH];
        w_y_min       = rq_screen_y_min[i*WIDTH +: WIDTH];
        w_x_range     = rq_screen_x_range[i*WIDTH +: WIDTH];
        w_y_range     = rq_screen_y_range[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_owner_next = (r_owner == OW'(N - 1)) ? '0 : r_owner + OW'(1);
  assign w_active     = (r_state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_owner <= w_pick;
            r_grant <= {{(N-1){1'b0}}, 1'b1} << w_pick;
            r_state <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          // A start in the same cycle as a dropped req keeps ownership.
          if (w_owner_start) begin
            r_state <= ST_BUSY;
          end else if (!w_owner_req) begin
            r_grant <= '0;
            r_ptr   <= w_owner_next;
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (screen_done) r_state <= ST_OWNED;
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign grant             = r_grant;
  assign screen_start      = (r_state == ST_OWNED) && w_owner_start;
  assign new_screen_colour = w_active ? w_colour  : '0;
  assign screen_x_min      = w_active ? w_x_min   : '0;
  assign screen_y_min      = w_active ? w_y_min   : '0;
  assign screen_x_range    = w_active ? w_x_range : '0;
  assign screen_y_range    = w_active ? w_y_range : '0;
  assign rq_screen_done    = ((r_state == ST_BUSY) && screen_done) ? r_grant : '0;

  assign rq_screen_x          = screen_x;
  assign rq_screen_y          = screen_y;
  assign rq_old_screen_colour = old_screen_colour;

endmodule

`default_nettype wire

// File: tb/tb_screen_arbiter.sv
// ----------------------------------------------------------------------------
// tb_screen_arbiter : randomized self-checking bench for screen_arbiter.
// Revision          : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_screen_arbiter;

  localparam int WIDTH = 16;
  localparam int CW    = 3;
  localparam int N     = 3;

  logic                 clock;
  logic                 reset;
  logic [N-1:0]         req;
  logic [N-1:0]         grant;
  logic [N-1:0]         rq_screen_start;
  logic [N*CW-1:0]      rq_new_screen_colour;
  logic [N*WIDTH-1:0]   rq_screen_x_min;
  logic [N*WIDTH-1:0]   rq_screen_y_min;
  logic [N*WIDTH-1:0]   rq_screen_x_range;
  logic [N*WIDTH-1:0]   rq_screen_y_range;
  logic [N-1:0]         rq_screen_done;
  logic [WIDTH-1:0]     rq_screen_x;
  logic [WIDTH-1:0]     rq_screen_y;
  logic [CW-1:0]        rq_old_screen_colour;
  logic                 screen_start;
  logic [CW-1:0]        new_screen_colour;
  logic [WIDTH-1:0]     screen_x_min;
  logic [WIDTH-1:0]     screen_y_min;
  logic [WIDTH-1:0]     screen_x_range;
  logic [WIDTH-1:0]     screen_y_range;
  logic [WIDTH-1:0]     screen_x;
  logic [WIDTH-1:0]     screen_y;
  logic [CW-1:0]        old_screen_colour;
  logic                 screen_done;

  screen_arbiter #(.WIDTH(WIDTH), .COLOUR_WIDTH(CW), .N(N)) dut (
    .clock                (clock),
    .reset                (reset),
    .req                  (req),
    .grant                (grant),
    .rq_screen_start      (rq_screen_start),
    .rq_new_screen_colour (rq_new_screen_colour),
    .rq_screen_x_min      (rq_screen_x_min),
    .rq_screen_y_min      (rq_screen_y_min),
    .rq_screen_x_range    (rq_screen_x_range),
    .rq_screen_y_range    (rq_screen_y_range),
    .rq_screen_done       (rq_screen_done),
    .rq_screen_x          (rq_screen_x),
    .rq_screen_y          (rq_screen_y),
    .rq_old_screen_colour (rq_old_screen_colour),
    .screen_start         (screen_start),
    .new_screen_colour    (new_screen_colour),
    .screen_x_min         (screen_x_min),
    .screen_y_min         (screen_y_min),
    .screen_x_range       (screen_x_range),
    .screen_y_range       (screen_y_range),
    .screen_x             (screen_x),
    .screen_y             (screen_y),
    .old_screen_colour    (old_screen_colour),
    .screen_done          (screen_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests;
  int n_fail;

  // Reference model: who owns the writer (-1 = nobody), whether an operation
  // is outstanding, and which requester the next search begins at.
  int m_owner;
  bit m_busy;
  int m_ptr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] slice(input logic [63:0] bus, input int idx, input int w);
    return (bus >> (idx * w)) & ((64'd1 << w) - 64'd1);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_busy  = 1'b0;
    m_ptr   = 0;
  endtask

  // Compare outputs mid-cycle, then advance the model across the next edge.
  task automatic do_cycle();
    logic [N-1:0] e_grant;
    logic [N-1:0] e_done;
    logic         e_start;
    int           o;
    #4;
    o       = m_owner;
    e_grant = (o >= 0) ? N'(1 << o) : '0;
    e_start = (o >= 0) && !m_busy && rq_screen_start[o];
    e_done  = (o >= 0) && m_busy && screen_done ? N'(1 << o) : '0;
    check("grant", 64'(grant), 64'(e_grant));
    check("screen_start", 64'(screen_start), 64'(e_start));
    check("rq_screen_done", 64'(rq_screen_done), 64'(e_done));
    check("colour", 64'(new_screen_colour), (o >= 0) ? slice(64'(rq_new_screen_colour), o, CW) : 64'd0);
    check("x_min", 64'(screen_x_min), (o >= 0) ? slice(64'(rq_screen_x_min), o, WIDTH) : 64'd0);
    check("y_min", 64'(screen_y_min), (o >= 0) ? slice(64'(rq_screen_y_min), o, WIDTH) : 64'd0);
    check("x_range", 64'(screen_x_range), (o >= 0) ? slice(64'(rq_screen_x_range), o, WIDTH) : 64'd0);
    check("y_range", 64'(screen_y_range), (o >= 0) ? slice(64'(rq_screen_y_range), o, WIDTH) : 64'd0);
    check("ret_x", 64'(rq_screen_x), 64'(screen_x));
    check("ret_y", 64'(rq_screen_y), 64'(screen_y));
    check("ret_colour", 64'(rq_old_screen_colour), 64'(old_screen_colour));

    if (reset) begin
      model_reset();
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end
    end else if (!m_busy) begin
      if (rq_screen_start[m_owner]) begin
        m_busy = 1'b1;
      end else if (!req[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end else if (screen_done) begin
      m_busy = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(7) == 0) req[i] = ~req[i];
      rq_screen_start[i] = ($urandom_range(3) == 0);
    end
    screen_done = ($urandom_range(4) == 0);
    reset       = ($urandom_range(150) == 0);
    if ($urandom_range(1) == 0) begin
      rq_new_screen_colour = (N*CW)'($urandom());
      rq_screen_x_min      = (N*WIDTH)'({$urandom(), $urandom()});
      rq_screen_y_min      = (N*WIDTH)'({$urandom(), $urandom()});
      rq_screen_x_range    = (N*WIDTH)'({$urandom(), $urandom()});
      rq_screen_y_range    = (N*WIDTH)'({$urandom(), $urandom()});
    end
    screen_x          = WIDTH'($urandom());
    screen_y          = WIDTH'($urandom());
    old_screen_colour = CW'($urandom());
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    req     = '0;
    rq_screen_start      = '0;
    rq_new_screen_colour = '0;
    rq_screen_x_min      = '0;
    rq_screen_y_min      = '0;
    rq_screen_x_range    = '0;
    rq_screen_y_range    = '0;
    screen_x          = '0;
    screen_y          = '0;
    old_screen_colour = '0;
    screen_done       = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    reset = 1'b0;

    // Idle after reset with non-zero windows present: outputs must stay zero.
    rq_new_screen_colour = '1;
    rq_screen_x_min      = '1;
    repeat (10) do_cycle();

    for (int c = 0; c < 4000; c++) begin
      randomize_inputs();
      do_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
